// File: rtl/tile_eval_scheduler_pkg.sv
// Shared constants for the tile evaluation scheduler: default sizes,
// condition bit positions used by the evaluation function, counter width.
package tile_eval_scheduler_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int COND_W_DEF = 6;

    localparam int C_A0 = 0;
    localparam int C_A1 = 1;
    localparam int C_A2 = 2;
    localparam int C_A3 = 3;
    localparam int C_A4 = 4;
    localparam int C_A5 = 5;

    localparam int CNT_W = 8;

endpackage

// File: rtl/tile_eval_core.sv
// Combinational evaluation of one condition slice; the result is active-low
// (0 means the hit term fired).
module tile_eval_core
    import tile_eval_scheduler_pkg::*;
#(
    parameter int COND_W = COND_W_DEF
) (
    input  logic [COND_W-1:0] i_cond,
    output logic              o_result
);

    logic w_a;
    logic w_b;
    logic w_x;
    logic w_hit;

    assign w_a   = i_cond[C_A3] & i_cond[C_A4];
    assign w_b   = i_cond[C_A1] & i_cond[C_A2];
    assign w_x   = i_cond[C_A5] ^ w_b;
    assign w_hit = (w_x & w_a & i_cond[C_A2])
                 | ((w_x | w_a) & i_cond[C_A0])
                 | (~w_a & i_cond[C_A5])
                 | i_cond[C_A1];

    assign o_result = ~w_hit;

endmodule

// File: rtl/tile_eval_scheduler.sv
// Two-stage scheduler: a round-robin grant stage captures one requester's
// condition, the following edge posts the result, ack pulse and count.
module tile_eval_scheduler
    import tile_eval_scheduler_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int COND_W = COND_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ena,
    input  logic [N_CH-1:0]          i_req,
    input  logic [N_CH*COND_W-1:0]   i_cond,
    output logic [N_CH-1:0]          o_ack,
    output logic [N_CH-1:0]          o_chan_out,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_eval_cnt
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              r_stageValid;
    logic [IDX_W-1:0]  r_stageIdx;
    logic [COND_W-1:0] r_stageCond;
    logic [IDX_W-1:0]  r_lastGrant;
    logic [N_CH-1:0]   r_ack;
    logic [N_CH-1:0]   r_chanOut;
    logic [CNT_W-1:0]  r_evalCnt;

    logic [N_CH-1:0]   w_inStage;
    logic [N_CH-1:0]   w_eligible;
    logic              w_grantValid;
    logic [IDX_W-1:0]  w_grantIdx;
    logic [COND_W-1:0] w_grantCond;
    logic              w_result;

    tile_eval_core #(
        .COND_W (COND_W)
    ) u_core (
        .i_cond   (r_stageCond),
        .o_result (w_result)
    );

    always_comb begin
        w_inStage = '0;
        if (r_stageValid) begin
            w_inStage[r_stageIdx] = 1'b1;
        end
    end

    assign w_eligible = i_req & ~w_inStage;

    // Walk from farthest to nearest so the channel right after the last
    // grant is the one left standing.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (w_eligible[(int'(r_lastGrant) + k) % N_CH]) begin
                w_grantValid = i_ena;
                w_grantIdx   = IDX_W'((int'(r_lastGrant) + k) % N_CH);
            end
        end
    end

    assign w_grantCond = i_cond[int'(w_grantIdx)*COND_W +: COND_W];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stageValid <= 1'b0;
            r_stageIdx   <= '0;
            r_stageCond  <= '0;
            r_lastGrant  <= IDX_W'(N_CH - 1);
            r_ack        <= '0;
            r_chanOut    <= '1;
            r_evalCnt    <= '0;
        end else begin
            r_ack <= '0;
            if (r_stageValid) begin
                r_chanOut[r_stageIdx] <= w_result;
                r_ack[r_stageIdx]     <= 1'b1;
                r_evalCnt             <= r_evalCnt + CNT_W'(1);
            end
            r_stageValid <= w_grantValid;
            if (w_grantValid) begin
                r_stageIdx  <= w_grantIdx;
                r_stageCond <= w_grantCond;
                r_lastGrant <= w_grantIdx;
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_chan_out = r_chanOut;
    assign o_busy     = r_stageValid;
    assign o_eval_cnt = r_evalCnt;

endmodule

// File: tb/tb_tile_eval_scheduler.sv
// Directed bench for tile_eval_scheduler: grant/complete latency, rotation,
// enable gating, reset mid-flight, counter wrap and randomized results.
module tb_tile_eval_scheduler;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [23:0] cond;
    logic [3:0]  ack;
    logic [3:0]  chanOut;
    logic        busy;
    logic [7:0]  evalCnt;

    int checks;
    int failures;

    tile_eval_scheduler #(
        .N_CH   (4),
        .COND_W (6)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ena      (ena),
        .i_req      (req),
        .i_cond     (cond),
        .o_ack      (ack),
        .o_chan_out (chanOut),
        .o_busy     (busy),
        .o_eval_cnt (evalCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic refResult(input logic [5:0] c);
        logic a, b, x, hit;
        a   = c[3] & c[4];
        b   = c[1] & c[2];
        x   = c[5] ^ b;
        hit = (x & a & c[2]) | ((x | a) & c[0]) | (~a & c[5]) | c[1];
        return ~hit;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        ena = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        ena  = 1'b0;
        req  = 4'b0000;
        cond = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
        checks++;
        if (chanOut !== 4'b1111) begin failures++; $display("[TB] FAIL reset_chan_out: got %b expected 1111", chanOut); end
        checks++;
        if (evalCnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", evalCnt); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        logic [5:0] vec [3];
        logic       expv [3];
        vec  = '{6'b000000, 6'b100000, 6'b000010};
        expv = '{1'b1, 1'b0, 1'b0};
        ena  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cond[5:0] = vec[i];
            req = 4'b0001;
            tick();
            checks++;
            if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_%0d: got %b expected 1", i, busy); end
            checks++;
            if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL basic_early_ack_%0d: got %b expected 0000", i, ack); end
            // Change cond while in flight; the captured value must win.
            if (i == 2) cond[5:0] = 6'b000000;
            tick();
            checks++;
            if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL basic_ack_%0d: got %b expected 0001", i, ack); end
            checks++;
            if (chanOut[0] !== expv[i]) begin failures++; $display("[TB] FAIL basic_result_%0d: got %b expected %b", i, chanOut[0], expv[i]); end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle_%0d: got %b expected 0", i, busy); end
            req = 4'b0000;
            tick();
            checks++;
            if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL basic_ack_clear_%0d: got %b expected 0000", i, ack); end
        end
        checks++;
        if (evalCnt !== 8'd3) begin failures++; $display("[TB] FAIL basic_cnt: got %0d expected 3", evalCnt); end
    endtask

    task automatic test_round_robin_all;
        logic [3:0] expAck [6];
        logic [5:0] c [4];
        logic [3:0] expOut;
        expAck = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        c      = '{6'b000000, 6'b000010, 6'b001101, 6'b100001};
        doReset();
        for (int ch = 0; ch < 4; ch++) begin
            cond[ch*6 +: 6] = c[ch];
            expOut[ch] = refResult(c[ch]);
        end
        req = 4'b1111;
        ena = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if (ack !== expAck[t]) begin failures++; $display("[TB] FAIL rr_ack_%0d: got %b expected %b", t, ack, expAck[t]); end
            req = req & ~ack;
        end
        checks++;
        if (evalCnt !== 8'd4) begin failures++; $display("[TB] FAIL rr_cnt: got %0d expected 4", evalCnt); end
        checks++;
        if (chanOut !== expOut) begin failures++; $display("[TB] FAIL rr_chan_out: got %b expected %b", chanOut, expOut); end
    endtask

    task automatic test_alternate;
        logic [3:0] expAck [4];
        expAck = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        doReset();
        cond = '0;
        req  = 4'b0101;
        ena  = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL alt_first: got %b expected 0000", ack); end
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (ack !== expAck[t]) begin failures++; $display("[TB] FAIL alt_ack_%0d: got %b expected %b", t, ack, expAck[t]); end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL alt_drain: got %b expected 0001", ack); end
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin failures++; $display("[TB] FAIL alt_idle: got busy=%b ack=%b expected busy=0 ack=0000", busy, ack); end
    endtask

    task automatic test_ena_gate;
        doReset();
        req = 4'b1111;
        ena = 1'b1;
        tick();
        tick();
        checks++;
        if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL ena_ack0: got %b expected 0001", ack); end
        ena = 1'b0;
        tick();
        checks++;
        if (ack !== 4'b0010) begin failures++; $display("[TB] FAIL ena_inflight: got %b expected 0010", ack); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ena_busy: got %b expected 0", busy); end
        for (int t = 0; t < 2; t++) begin
            tick();
            checks++;
            if (ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL ena_blocked_%0d: got ack=%b busy=%b expected 0000/0", t, ack, busy); end
        end
        ena = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ena_resume_busy: got %b expected 1", busy); end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0100) begin failures++; $display("[TB] FAIL ena_resume_ack: got %b expected 0100", ack); end
        tick();
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL ena_end: got %b expected 0000", ack); end
    endtask

    task automatic test_reset_inflight;
        doReset();
        cond[5:0] = 6'b100000;
        req = 4'b0001;
        ena = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (chanOut !== 4'b1110) begin failures++; $display("[TB] FAIL rif_pre: got %b expected 1110", chanOut); end
        cond[11:6] = 6'b100000;
        req = 4'b0010;
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rif_busy: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rif_state: got ack=%b busy=%b expected 0000/0", ack, busy); end
        checks++;
        if (chanOut !== 4'b1111) begin failures++; $display("[TB] FAIL rif_chan_out: got %b expected 1111", chanOut); end
        checks++;
        if (evalCnt !== 8'd0) begin failures++; $display("[TB] FAIL rif_cnt: got %0d expected 0", evalCnt); end
        tick();
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL rif_discard: got %b expected 0000", ack); end
        req = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL rif_next: got %b expected 0001", ack); end
    endtask

    task automatic test_wrap_random;
        logic [5:0] shadow [4];
        int         ackCount;
        doReset();
        for (int ch = 0; ch < 4; ch++) begin
            shadow[ch] = 6'($urandom_range(0, 63));
            cond[ch*6 +: 6] = shadow[ch];
        end
        req = 4'b1111;
        ena = 1'b1;
        ackCount = 0;
        for (int cyc = 0; cyc < 600 && ackCount < 256; cyc++) begin
            tick();
            if (ack !== 4'b0000) begin
                checks++;
                if (!$onehot(ack)) begin failures++; $display("[TB] FAIL rnd_onehot: got %b expected one-hot", ack); end
                for (int ch = 0; ch < 4; ch++) begin
                    if (ack[ch]) begin
                        checks++;
                        if (chanOut[ch] !== refResult(shadow[ch])) begin
                            failures++;
                            $display("[TB] FAIL rnd_result ch%0d cond=%b: got %b expected %b", ch, shadow[ch], chanOut[ch], refResult(shadow[ch]));
                        end
                        ackCount++;
                        shadow[ch] = 6'($urandom_range(0, 63));
                        cond[ch*6 +: 6] = shadow[ch];
                    end
                end
            end
        end
        checks++;
        if (ackCount != 256) begin failures++; $display("[TB] FAIL rnd_ack_budget: got %0d acks expected 256", ackCount); end
        checks++;
        if (evalCnt !== 8'd0) begin failures++; $display("[TB] FAIL wrap_cnt: got %0d expected 0", evalCnt); end
        req = 4'b0000;
        tick();
        checks++;
        if (!$onehot(ack)) begin failures++; $display("[TB] FAIL wrap_drain_ack: got %b expected one-hot", ack); end
        for (int ch = 0; ch < 4; ch++) begin
            if (ack[ch]) begin
                checks++;
                if (chanOut[ch] !== refResult(shadow[ch])) begin failures++; $display("[TB] FAIL wrap_drain_result ch%0d: got %b expected %b", ch, chanOut[ch], refResult(shadow[ch])); end
            end
        end
        checks++;
        if (evalCnt !== 8'd1) begin failures++; $display("[TB] FAIL wrap_cnt_after: got %0d expected 1", evalCnt); end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wrap_idle: got %b expected 0", busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        ena  = 1'b0;
        req  = 4'b0000;
        cond = '0;
        $display("[TB] starting tile_eval_scheduler bench");
        test_reset();
        test_basic();
        test_round_robin_all();
        test_alternate();
        test_ena_gate();
        test_reset_inflight();
        test_wrap_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
